// File: rtl/cmplx_accum_round_pkg.sv
// cmplx_pkg: shared widths and types for the complex accumulate/round stage.
//   IN_W       - signed width of incoming I/Q products from the multiplier
//   OUT_W      - signed width of the rounded I/Q results
//   cplx_in_t  - packed I/Q pair at IN_W
//   cplx_out_t - packed I/Q pair at OUT_W
//   cplx_state_t - accumulator controller states
package cmplx_pkg;

  localparam int IN_W  = 37;
  localparam int OUT_W = 18;

  typedef struct packed {
    logic signed [IN_W-1:0] i;
    logic signed [IN_W-1:0] q;
  } cplx_in_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] i;
    logic signed [OUT_W-1:0] q;
  } cplx_out_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } cplx_state_t;

endpackage

// File: rtl/cmplx_accum_round_round_sat.sv
// round_sat: combinational round-half-up, arithmetic right shift and
// saturation of one accumulator channel.
//   acc_i  - signed accumulator value (ACC_W bits)
//   data_o - signed rounded/saturated result (OUT_W bits)
//   clip_o - high when the rounded value had to be clamped
module round_sat #(
  parameter int ACC_W = 41,
  parameter int SHIFT = 22,
  parameter int OUT_W = 18
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    clip_o
);

  // One guard bit above the accumulator so adding the half-LSB cannot wrap.
  localparam logic signed [ACC_W:0]   HALF  = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   MAX_W = {{(ACC_W+1-OUT_W){1'b0}}, MAX_O};
  localparam logic signed [ACC_W:0]   MIN_W = {{(ACC_W+1-OUT_W){1'b1}}, MIN_O};

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shr;

  always_comb begin
    sum    = {acc_i[ACC_W-1], acc_i} + HALF;
    // Arithmetic shift floors toward -inf, which with +HALF gives round-half-up.
    shr    = sum >>> SHIFT;
    data_o = shr[OUT_W-1:0];
    clip_o = 1'b0;
    if (shr > MAX_W) begin
      data_o = MAX_O;
      clip_o = 1'b1;
    end else if (shr < MIN_W) begin
      data_o = MIN_O;
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/cmplx_accum_round.sv
// cmplx_accum_round: accumulates ACC_LEN complex products per block, then
// rounds and saturates each channel to OUT_W bits and holds the result
// until the downstream stage takes it.
//   clk_i, srst_i        - clock (rising edge), async active-high reset
//   data_i_i, data_q_i   - signed I/Q products (IN_W)
//   valid_i / ready_o    - input handshake
//   data_i_o, data_q_o   - signed rounded block sums (OUT_W)
//   valid_o / ready_i    - output handshake
//   sat_o                - either channel clipped in the presented result
// IN_W/OUT_W are taken from cmplx_pkg so the packed I/Q types line up.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ACCUM | accepting samples, summing into acc_*_q
// ST_ROUND | one cycle: register rounded/saturated sums and clip flag
// ST_HOLD  | result valid, waiting for ready_i; input stalled
module cmplx_accum_round
  import cmplx_pkg::*;
#(
  parameter int ACC_LEN = 16,
  parameter int ACC_W   = IN_W + $clog2(ACC_LEN),
  parameter int SHIFT   = 22
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic signed [IN_W-1:0]  data_i_i,
  input  logic signed [IN_W-1:0]  data_q_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic signed [OUT_W-1:0] data_i_o,
  output logic signed [OUT_W-1:0] data_q_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    sat_o
);

  localparam int              CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  cplx_state_t             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] acc_i_d, acc_q_d;
  logic                    ready_q, valid_q, sat_q;
  cplx_out_t               res_q;

  cplx_in_t                smp;
  logic signed [OUT_W-1:0] rnd_i, rnd_q;
  logic                    clip_i, clip_q;
  logic                    accept;

  assign smp    = '{i: data_i_i, q: data_q_i};
  assign accept = valid_i && ready_q;

  assign acc_i_d = acc_i_q + {{(ACC_W-IN_W){smp.i[IN_W-1]}}, smp.i};
  assign acc_q_d = acc_q_q + {{(ACC_W-IN_W){smp.q[IN_W-1]}}, smp.q};

  round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_i (
    .acc_i  (acc_i_q),
    .data_o (rnd_i),
    .clip_o (clip_i)
  );

  round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_q (
    .acc_i  (acc_q_q),
    .data_o (rnd_q),
    .clip_o (clip_q)
  );

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              ready_q <= 1'b0;
              state_q <= ST_ROUND;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_ROUND: begin
          res_q   <= '{i: rnd_i, q: rnd_q};
          sat_q   <= clip_i | clip_q;
          valid_q <= 1'b1;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            acc_i_q <= '0;
            acc_q_q <= '0;
            state_q <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign data_i_o = res_q.i;
  assign data_q_o = res_q.q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_cmplx_accum_round.sv
module tb_cmplx_accum_round;

  logic               clk_i = 1'b0;
  logic               srst_i;
  logic signed [36:0] data_i_i, data_q_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [17:0] data_i_o, data_q_o;
  logic               valid_o;
  logic               ready_i;
  logic               sat_o;

  int n_vec = 0;
  int n_err = 0;

  cmplx_accum_round dut (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .data_i_i (data_i_i),
    .data_q_i (data_q_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i_o (data_i_o),
    .data_q_o (data_q_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .sat_o    (sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Offers samples from negedges until n have been accepted; returns at the
  // negedge following the edge that took the last one, with valid_i low.
  task automatic feed(input longint vi, input longint vq, input int n,
                      input bit gaps, input string tag);
    logic signed [63:0] wi, wq;
    int  got = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    wi = vi;
    wq = vq;
    while (got < n && cyc < 200) begin
      @(negedge clk_i);
      data_i_i = wi[36:0];
      data_q_i = wq[36:0];
      valid_i  = gaps ? tog : 1'b1;
      tog      = !tog;
      if (valid_i && ready_o) got++;
      cyc++;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    if (got < n) chk({tag, "_feed_timeout"}, got, n);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (!valid_o) chk({tag, "_timeout"}, valid_o, 1);
  endtask

  task automatic check_result(input string tag, input longint ei,
                              input longint eq, input bit es);
    wait_valid(tag);
    chk({tag, "_i"}, data_i_o, ei);
    chk({tag, "_q"}, data_q_o, eq);
    chk({tag, "_sat"}, sat_o, es);
    if (ready_i) begin
      @(negedge clk_i);
      chk({tag, "_vdrop"}, valid_o, 0);
    end
  endtask

  initial begin
    logic signed [17:0] hold_i, hold_q;
    srst_i   = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    data_i_i = '0;
    data_q_i = '0;

    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_di", data_i_o, 0);
    chk("rst_dq", data_q_o, 0);
    chk("rst_sat", sat_o, 0);
    @(negedge clk_i);
    srst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);

    // 1: basic sum and 2-edge latency
    feed(64'sd4194304, -64'sd4194304, 16, 1'b0, "basic");
    chk("basic_lat1", valid_o, 0);
    chk("basic_rdy_round", ready_o, 0);
    @(negedge clk_i);
    chk("basic_lat2", valid_o, 1);
    chk("basic_i", data_i_o, 16);
    chk("basic_q", data_q_o, -16);
    chk("basic_sat", sat_o, 0);
    @(negedge clk_i);
    chk("basic_one_cycle", valid_o, 0);
    chk("basic_rdy_back", ready_o, 1);

    // 2: rounding tie, half rounds up on both signs
    feed(64'sd131072, -64'sd131072, 16, 1'b0, "tie");
    check_result("tie", 1, 0, 1'b0);

    // 3: saturation, then a clean zero block
    feed(64'sd68719476735, -64'sd68719476736, 16, 1'b0, "sat");
    check_result("sat", 131071, -131072, 1'b1);
    feed(0, 0, 16, 1'b0, "zero");
    check_result("zero", 0, 0, 1'b0);

    // 4: gaps in valid_i and output backpressure
    ready_i = 1'b0;
    feed(64'sd4194304, 64'sd8388608, 16, 1'b1, "bp");
    wait_valid("bp");
    hold_i = data_i_o;
    hold_q = data_q_o;
    chk("bp_i", hold_i, 16);
    chk("bp_q", hold_q, 32);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      data_i_i = 37'sd1000000000;
      data_q_i = 37'sd1000000000;
      valid_i  = 1'b1;
      chk("bp_stall_rdy", ready_o, 0);
      chk("bp_stall_v", valid_o, 1);
      chk("bp_stall_i", data_i_o, hold_i);
      chk("bp_stall_q", data_q_o, hold_q);
    end
    @(negedge clk_i);
    ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("bp_hs_v", valid_o, 0);
    chk("bp_hs_rdy", ready_o, 1);
    feed(-64'sd4194304, 64'sd1048576, 16, 1'b1, "bp2");
    check_result("bp2", -16, 4, 1'b0);

    // 5: async reset mid-block
    feed(64'sd4194304, 64'sd4194304, 7, 1'b0, "mid");
    #2 srst_i = 1'b1;
    #1;
    chk("mid_rst_v", valid_o, 0);
    chk("mid_rst_i", data_i_o, 0);
    chk("mid_rst_q", data_q_o, 0);
    #1 srst_i = 1'b0;
    feed(64'sd4194304, 0, 16, 1'b0, "post");
    check_result("post", 16, 0, 1'b0);

    // 6: reset while holding a result
    ready_i = 1'b0;
    feed(64'sd8388608, -64'sd8388608, 16, 1'b0, "hold");
    wait_valid("hold");
    chk("hold_i", data_i_o, 32);
    #2 srst_i = 1'b1;
    #1;
    chk("hold_rst_v", valid_o, 0);
    chk("hold_rst_i", data_i_o, 0);
    chk("hold_rst_q", data_q_o, 0);
    #1 srst_i = 1'b0;
    @(negedge clk_i);
    chk("hold_rdy", ready_o, 1);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("hold_no_result", valid_o, 0);
    end
    feed(64'sd4194304, 64'sd4194304, 16, 1'b0, "after");
    check_result("after", 16, 16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
